// File: rtl/ast_pkg.sv
// Shared types and width helpers for the ast gather/scatter buffers.
package ast_pkg;

    typedef enum logic {GATHER_FILL, GATHER_HOLD} gather_state_t;

    // Bits needed to hold a count in 0..depth.
    function automatic int cw_of(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ast_gather_fifo_if.sv
// Serial word input and parallel array output bundle of the gather buffer.
interface ast_gather_fifo_if #(
    parameter int DEPTH     = 8,
    parameter int DATAWIDTH = 8
);
    import ast_pkg::*;

    localparam int CW = cw_of(DEPTH);

    logic                 in_valid;
    logic                 in_ready;
    logic [DATAWIDTH-1:0] data_in;
    logic                 in_last;
    logic [DATAWIDTH-1:0] array_out [DEPTH-1:0];
    logic [CW-1:0]        count;
    logic                 array_valid;
    logic                 array_ready;
    logic                 empty;
    logic                 full;

    modport master (
        output in_valid, data_in, in_last, array_ready,
        input  in_ready, array_out, count, array_valid, empty, full
    );

    modport slave (
        input  in_valid, data_in, in_last, array_ready,
        output in_ready, array_out, count, array_valid, empty, full
    );

endinterface

// File: rtl/ast_gather_fifo.sv
// Gathers up to DEPTH serial words into a parallel array; array_valid rises the cycle after the final accept.
// Backpressure: in_ready is low while the array is held, so the producer must hold its word until handoff.
module ast_gather_fifo
    import ast_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int DATAWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    ast_gather_fifo_if.slave  bus
);

    localparam int CW = cw_of(DEPTH);
    localparam int PW = $clog2(DEPTH);

    gather_state_t        state_q;
    gather_state_t        state_d;
    logic [PW-1:0]        wr_ptr_q;
    logic [DATAWIDTH-1:0] mem_q [DEPTH-1:0];
    logic [CW-1:0]        count_q;

    logic in_ready_c;
    logic accept;
    logic last_accept;
    logic handoff;

    // clr and reset both block input so a word offered that cycle stays with the producer.
    assign in_ready_c  = rst_n && !clr && (state_q == GATHER_FILL);
    assign accept      = bus.in_valid && in_ready_c;
    assign last_accept = accept && (bus.in_last || (wr_ptr_q == PW'(DEPTH - 1)));
    assign handoff     = (state_q == GATHER_HOLD) && bus.array_ready && !clr;

    always_comb begin
        state_d = state_q;
        if (clr || handoff) begin
            state_d = GATHER_FILL;
        end else if (last_accept) begin
            state_d = GATHER_HOLD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= GATHER_FILL;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (clr || handoff) begin
                wr_ptr_q <= '0;
                count_q  <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
            end else if (accept) begin
                mem_q[wr_ptr_q] <= bus.data_in;
                // The pointer parks on the final slot rather than wrapping; handoff resets it.
                if (last_accept) begin
                    count_q <= CW'(wr_ptr_q) + CW'(1);
                end else begin
                    wr_ptr_q <= wr_ptr_q + PW'(1);
                end
            end
        end
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.array_out   = mem_q;
    assign bus.count       = count_q;
    assign bus.array_valid = (state_q == GATHER_HOLD);
    assign bus.full        = (state_q == GATHER_HOLD);
    assign bus.empty       = (state_q == GATHER_FILL) && (wr_ptr_q == '0);

endmodule

// File: doc/ast_gather_fifo.md
# ast_gather_fifo

Serial-in, parallel-out gather buffer: the unloading counterpart of the team's parallel-load/serial-pop FIFO. Accepts a stream of words over a valid/ready handshake, packs them into a DEPTH-entry array, and presents the whole array at once on a parallel valid/ready port. Sits at the output side of a compute stage, rebuilding vectors for the next parallel-load consumer. Unfilled slots after an early `in_last` are zero-padded.

## Interface
- `DEPTH`, 8, number of array entries (≥2)
- `DATAWIDTH`, 8, bits per word
- `CW` (localparam), `$clog2(DEPTH+1)`, width of the count output

Ports:
- `clk`  in  1  clock; all state changes on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `clr`  in  1  synchronous clear of pointer, state and array
- `in_valid`  in  1  `data_in` holds a word
- `in_ready`  out  1  block can accept a word this cycle
- `data_in`  in  DATAWIDTH  serial word
- `in_last`  in  1  qualifies final word of a short vector
- `array_out`  out  DATAWIDTH × DEPTH (unpacked `[DEPTH-1:0]`)  gathered array; index 0 = first word accepted
- `count`  out  CW  valid words in `array_out` (1..DEPTH when `array_valid`)
- `array_valid`  out  1  `array_out`/`count` are stable and complete
- `array_ready`  in  1  consumer takes the array this cycle
- `empty`  out  1  no word gathered since last clear/handoff
- `full`  out  1  equals `array_valid`

## Operation
- Two-state FSM, `FILL` and `HOLD`.
- `FILL`:
  - `in_ready` = 1.
  - Accept occurs when `in_valid & in_ready`: `mem[wr_ptr] <= data_in`, then `wr_ptr` increments.
  - Accept with `wr_ptr == DEPTH-1`, or with `in_last` = 1, goes to `HOLD`. It sets `array_valid`, and `count <= wr_ptr+1`.
  - `in_last` without `in_valid` is ignored.
- `HOLD`:
  - `in_ready` = 0.
  - `array_out` and `count` are frozen.
  - `array_valid & array_ready` returns to `FILL`. `wr_ptr`, `count` and `array_valid` go to 0, and all `mem` entries are zeroed.
- `empty` = (`state == FILL`) & (`wr_ptr == 0`).
- `wr_ptr` is `$clog2(DEPTH)` bits wide and never wraps. The `HOLD` transition precedes any overflow.
- Priority, highest first: `rst_n` low, `clr`, handoff/accept.
- `clr` high:
  - Same effect as a handoff, from either state.
  - `in_ready` is forced 0 that cycle, so no word is lost.
  - `array_ready` is ignored that cycle.
- Reset mid-fill or mid-hold discards all contents; no partial array is emitted.

## Timing
- Reset values (asynchronous, while `rst_n` = 0):
  - state `FILL`, `wr_ptr` 0, `mem` all 0
  - `array_valid` 0, `count` 0, `full` 0, `empty` 1
  - `in_ready` 0 (gated by `rst_n`)
- `in_ready` is combinational from state, `clr` and `rst_n`. It has no combinational path from `in_valid` or `array_ready`.
- Latency: the DEPTH-th (or `in_last`) accept at edge k gives `array_valid` = 1 after edge k.
- Minimum vector period is DEPTH+1 cycles:
  - DEPTH accept cycles, plus one `HOLD` cycle when `array_ready` is held high.
  - First accept of the next vector is at edge k+2 at the earliest.
- `array_valid`, once high, stays high with `array_out` unchanged until the handoff edge or `clr`.
- A word presented while `in_ready` = 0 must be held by the producer. The block does not drop words under backpressure.

## Structure
- Shared package `ast_pkg`:
  - `typedef enum logic {GATHER_FILL, GATHER_HOLD} gather_state_t`
  - any common width helper, e.g. `CW` function
- Single module, no sub-modules: storage, pointer and FSM are all in one block.
- `array_out` is driven directly from `mem` (registered). It has no output mux.

## Test plan
- Full vector, DEPTH=8, DATAWIDTH=8:
  - Stimulus: `in_valid` held with data 0x10..0x17, `array_ready` = 1.
  - Response: `array_valid` high exactly one cycle after the 8th accept, `array_out[0..7]` = 0x10..0x17, `count` = 8.
  - Next cycle: `empty` = 1 and `in_ready` = 1.
- Short vector:
  - Stimulus: words 0xA1, 0xA2, 0xA3, `in_last` on 0xA3.
  - Response: `count` = 3, `array_out[0..2]` = A1,A2,A3, `array_out[3..7]` = 0.
- Backpressure:
  - Stimulus: fill 8 words, hold `array_ready` = 0 for 5 cycles while `in_valid` = 1 with 0xFF.
  - Response: `in_ready` = 0 throughout, `array_out` unchanged, 0xFF is accepted only after the handoff, into index 0 of the next vector.
- Clear mid-fill:
  - Stimulus: 4 words accepted, then `clr` pulse with `in_valid` = 1.
  - Response: word not accepted, `empty` = 1, `wr_ptr` 0, `mem` all 0, no `array_valid`.
- Async reset in `HOLD`:
  - Stimulus: drop `rst_n` mid-cycle while `array_valid` = 1.
  - Response: `array_valid`, `count`, `in_ready` go 0 immediately without a clock edge.
  - After release: `empty` = 1, and a new full vector gathers correctly.
- Random valid/ready stress:
  - Stimulus: 1000 words with random `in_valid`, `array_ready` and `in_last`.
  - Response: the scoreboard's reconstructed vectors match the stimulus order exactly, with no loss and no duplication.
